// File: rtl/alu_pkg.sv
// Shared ALU package: base ALU op constants, multiply/divide op encodings,
// multiply/divide FSM state encoding and operand-signedness helpers.
package alu_pkg;

  // Base single-cycle ALU operations
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  // Multiply/divide operations; bit 2 marks the divide group, bit 1 the remainder pair
  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  // Multiply/divide sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

  // True when operand A is interpreted as two's complement
  function automatic logic mdu_a_signed(input mdu_op_e op);
    logic v;
    case (op)
      MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM: v = 1'b1;
      default:                                          v = 1'b0;
    endcase
    return v;
  endfunction

  // True when operand B is interpreted as two's complement
  function automatic logic mdu_b_signed(input mdu_op_e op);
    logic v;
    case (op)
      MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM: v = 1'b1;
      default:                             v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/alu_mdu_neg.sv
// Conditional two's-complement negate: o_val = i_neg ? -i_val : i_val.
module alu_mdu_neg #(
  parameter int N = 32
) (
  input  logic         i_neg,
  input  logic [N-1:0] i_val,
  output logic [N-1:0] o_val
);

  logic [N-1:0] w_inv_plus_one;

  assign w_inv_plus_one = ~i_val + {{(N-1){1'b0}}, 1'b1};
  assign o_val          = i_neg ? w_inv_plus_one : i_val;

endmodule

// File: rtl/alu_mdu.sv
// Iterative multiply/divide unit. Operands are reduced to magnitudes on
// accept, N shift-add (multiply) or restoring-subtract (divide) steps run in
// CALC, and the sign is restored in FIX. Divide hardware is built only when
// the macro ALU_MDU_DIV_EN is defined; otherwise OP 4-7 complete at once with 0.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         START,
  input  logic [2:0]   OP,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         BUSY,
  output logic         DONE,
  output logic [N-1:0] RESULT,
  output logic         ZERO
);

  localparam int            CW        = $clog2(N);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);
  localparam logic [N-1:0]  ALL_ZERO  = {N{1'b0}};
`ifdef ALU_MDU_DIV_EN
  localparam logic [N-1:0]  ALL_ONE   = {N{1'b1}};
  localparam logic [N-1:0]  MIN_NEG   = {1'b1, {(N-1){1'b0}}};
`endif

  mdu_state_e    r_state;
  mdu_op_e       r_op;
  logic          r_sa;
  logic          r_sb;
  logic [N-1:0]  r_hi;
  logic [N-1:0]  r_lo;
  logic [N-1:0]  r_b;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic [N-1:0]  r_result;
  logic          r_zero;

  mdu_op_e       w_op;
  logic          w_sa;
  logic          w_sb;
  logic [N-1:0]  w_abs_a;
  logic [N-1:0]  w_abs_b;
  logic          w_special;
  logic [N-1:0]  w_special_result;
  logic [N:0]    w_sum;
  logic [N-1:0]  w_step_hi;
  logic [N-1:0]  w_step_lo;
  logic          w_q_neg;
  logic          w_lo_zero;
  logic          w_hi_neg;
  logic [N-1:0]  w_neg_lo;
  logic [N-1:0]  w_neg_hi;
  logic [N-1:0]  w_fix_result;
`ifdef ALU_MDU_DIV_EN
  logic          w_b_zero;
  logic          w_ovf;
  logic [N:0]    w_shift;
  logic [N:0]    w_diff;
`endif

  assign w_op = mdu_op_e'(OP);
  assign w_sa = mdu_a_signed(w_op) & A[N-1];
  assign w_sb = mdu_b_signed(w_op) & B[N-1];

  // Operand magnitudes captured on accept
  alu_mdu_neg #(.N(N)) u_neg_a (.i_neg(w_sa), .i_val(A), .o_val(w_abs_a));
  alu_mdu_neg #(.N(N)) u_neg_b (.i_neg(w_sb), .i_val(B), .o_val(w_abs_b));

  // Sign correction of the low half (product low / quotient) and high half (product high / remainder)
  alu_mdu_neg #(.N(N)) u_neg_lo (.i_neg(w_q_neg), .i_val(r_lo), .o_val(w_neg_lo));
  alu_mdu_neg #(.N(N)) u_neg_hi (.i_neg(w_hi_neg), .i_val(r_hi), .o_val(w_neg_hi));

`ifdef ALU_MDU_DIV_EN
  // Detect divide-by-zero and signed overflow, which finish without iterating
  always_comb begin
    w_b_zero = (B == ALL_ZERO);
    w_ovf    = ((w_op == MDU_DIV) || (w_op == MDU_REM)) && (A == MIN_NEG) && (B == ALL_ONE);
    w_special = OP[2] && (w_b_zero || w_ovf);
    if (w_b_zero) begin
      w_special_result = OP[1] ? A : ALL_ONE;
    end else if (w_ovf) begin
      w_special_result = OP[1] ? ALL_ZERO : A;
    end else begin
      w_special_result = ALL_ZERO;
    end
  end
`else
  // Without divide hardware every divide-group op finishes at once with zero
  always_comb begin
    w_special        = OP[2];
    w_special_result = ALL_ZERO;
  end
`endif

  // One iteration step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(N+1){1'b0}});
    w_step_hi = w_sum[N:1];
    w_step_lo = {w_sum[0], r_lo[N-1:1]};
`ifdef ALU_MDU_DIV_EN
    w_shift = {r_hi, r_lo[N-1]};
    w_diff  = w_shift - {1'b0, r_b};
    if (r_op[2]) begin
      if (!w_diff[N]) begin
        w_step_hi = w_diff[N-1:0];
        w_step_lo = {r_lo[N-2:0], 1'b1};
      end else begin
        w_step_hi = w_shift[N-1:0];
        w_step_lo = {r_lo[N-2:0], 1'b0};
      end
    end else begin
      w_step_hi = w_sum[N:1];
    end
`endif
  end

  // Decide which halves need negating; a negated 2N-bit product only carries into the high half when the low half is zero
  always_comb begin
    w_lo_zero = (r_lo == ALL_ZERO);
    w_q_neg   = r_sa ^ r_sb;
`ifdef ALU_MDU_DIV_EN
    if (r_op[2] && r_op[1]) begin
      w_hi_neg = r_sa;
    end else begin
      w_hi_neg = w_q_neg & w_lo_zero;
    end
`else
    w_hi_neg = w_q_neg & w_lo_zero;
`endif
  end

  // Select the sign-corrected result for the finished operation
  always_comb begin
    w_fix_result = ALL_ZERO;
    case (r_op)
      MDU_MUL:                         w_fix_result = w_neg_lo;
      MDU_MULH, MDU_MULHSU, MDU_MULHU: w_fix_result = (w_q_neg && !w_lo_zero) ? ~r_hi : w_neg_hi;
`ifdef ALU_MDU_DIV_EN
      MDU_DIV, MDU_DIVU:               w_fix_result = w_neg_lo;
      MDU_REM, MDU_REMU:               w_fix_result = w_neg_hi;
`endif
      default:                         w_fix_result = ALL_ZERO;
    endcase
  end

  // Sequencer: accept in IDLE/DONE, iterate N cycles, correct sign, pulse DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= MDU_MUL;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_hi     <= ALL_ZERO;
      r_lo     <= ALL_ZERO;
      r_b      <= ALL_ZERO;
      r_cnt    <= {CW{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= ALL_ZERO;
      r_zero   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
          if (START) begin
            r_op <= w_op;
            r_sa <= w_sa;
            r_sb <= w_sb;
            if (w_special) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= w_special_result;
              r_zero   <= (w_special_result == ALL_ZERO);
            end else begin
              r_state <= S_CALC;
              r_busy  <= 1'b1;
              r_hi    <= ALL_ZERO;
              r_lo    <= w_abs_a;
              r_b     <= w_abs_b;
              r_cnt   <= {CW{1'b0}};
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_hi <= w_step_hi;
          r_lo <= w_step_lo;
          if (r_cnt == LAST_STEP) begin
            r_state <= S_FIX;
            r_cnt   <= {CW{1'b0}};
          end else begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_FIX: begin
          r_result <= w_fix_result;
          r_zero   <= (w_fix_result == ALL_ZERO);
          r_state  <= S_DONE;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_cnt   <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign BUSY   = r_busy;
  assign DONE   = r_done;
  assign RESULT = r_result;
  assign ZERO   = r_zero;

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu (N=32): stimulus pushes expected results,
// a negedge monitor pops and compares whenever DONE is presented.
module tb_alu_mdu;

  localparam int N = 32;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         START = 1'b0;
  logic [2:0]   OP    = 3'd0;
  logic [N-1:0] A     = '0;
  logic [N-1:0] B     = '0;
  logic         BUSY;
  logic         DONE;
  logic [N-1:0] RESULT;
  logic         ZERO;

  typedef struct {
    logic [N-1:0] res;
    logic         zero;
    int unsigned  cyc;
    string        name;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc   = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  alu_mdu #(.N(N)) dut (
    .clk(clk), .reset(reset), .START(START), .OP(OP), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .ZERO(ZERO)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every DONE pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && DONE) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got DONE at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_result"}, RESULT, e.res);
        check({e.name, "_zero"}, ZERO, e.zero);
        check({e.name, "_latency"}, cyc, e.cyc);
        check({e.name, "_busy_at_done"}, BUSY, 1'b0);
      end
    end
  end

  // Issue one request at a negedge; lat counts from the accepting edge (1 = immediate)
  task automatic issue(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] res, input int unsigned lat, input string name);
    exp_t e;
    e.res  = res;
    e.zero = (res == '0);
    e.cyc  = cyc + lat;
    e.name = name;
    sb_q.push_back(e);
    OP    = op;
    A     = a;
    B     = b;
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    check({name, "_busy_after_accept"}, BUSY, (lat > 1));
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!DONE && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!DONE) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_wait_done: got no DONE expected DONE within 100 cycles", name);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", BUSY, 1'b0);
    check("reset_done", DONE, 1'b0);
    check("reset_result", RESULT, 32'h0);
    check("reset_zero", ZERO, 1'b1);

    // Multiply with a START pulse mid-CALC that must be ignored
    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul_7_m3");
    repeat (5) @(negedge clk);
    OP = OP_MULHU; A = 32'h1234_5678; B = 32'h9ABC_DEF0; START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    drain();

    // Back-to-back starts issued in the DONE cycle
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu_max");
    wait_done("mulhu_max");
    issue(OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh_min");
    wait_done("mulh_min");
    issue(OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34, "mulhsu_m1_2");
    drain();

    issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0, 34, "mul_wrap_zero");
    drain();
    issue(OP_MULH, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34, "mulh_m1_2");
    drain();
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'd2, 32'h1, 34, "mulhu_max_2");
    drain();
    issue(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 34, "mulh_m1_m1");
    drain();

`ifdef ALU_MDU_DIV_EN
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, "rem_ovf");
    issue(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
    issue(OP_REM, 32'd5, 32'd0, 32'd5, 1, "rem_by0");
    drain();
    issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_m7_2");
    drain();
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_m7_2");
    drain();
    issue(OP_DIV, 32'd9, 32'd3, 32'd3, 34, "div_9_3");
    drain();
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 34, "divu_100_7");
    drain();
    issue(OP_REMU, 32'd100, 32'd7, 32'd2, 34, "remu_100_7");
    drain();
`else
    issue(OP_DIV, 32'd9, 32'd3, 32'h0, 1, "div_9_3_off");
    issue(OP_REMU, 32'd100, 32'd7, 32'h0, 1, "remu_off");
    issue(OP_DIVU, 32'd5, 32'd0, 32'h0, 1, "divu_by0_off");
    drain();
`endif

    // Leave a nonzero result, then reset during CALC
    issue(OP_MUL, 32'd6, 32'd7, 32'd42, 34, "mul_6_7");
    drain();
    OP = OP_MUL; A = 32'd3; B = 32'd5; START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    repeat (9) @(negedge clk);
    check("busy_mid_calc", BUSY, 1'b1);
    reset = 1'b1;
    #1;
    check("midreset_busy", BUSY, 1'b0);
    check("midreset_done", DONE, 1'b0);
    check("midreset_result", RESULT, 32'h0);
    check("midreset_zero", ZERO, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("post_reset_busy", BUSY, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand/result width in bits (even, >= 8).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port START  input  1  request strobe; sampled on clk rising edge.
REQ-005 SHALL have port OP  input  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 SHALL have port A  input  N  first operand (dividend / multiplicand).
REQ-007 SHALL have port B  input  N  second operand (divisor / multiplier).
REQ-008 SHALL have port BUSY  output  1  high while an operation is in progress.
REQ-009 SHALL have port DONE  output  1  one-cycle pulse; RESULT valid.
REQ-010 SHALL have port RESULT  output  N  registered result, held until next accepted START.
REQ-011 SHALL have port ZERO  output  1  registered, equals (RESULT == 0).

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-013 SHALL accept START only in IDLE or DONE; accepting captures OP, A, B and sets BUSY next cycle.
REQ-014 SHALL ignore START while in CALC or FIX; no state or operand change.
REQ-015 SHALL iterate CALC exactly N cycles (one shift-add or restoring-subtract step each), then FIX one cycle, then DONE.
REQ-016 SHALL assert DONE exactly N+2 cycles after the edge accepting START, for one cycle; BUSY low in that cycle.
REQ-017 SHALL operate on magnitudes and apply sign correction in FIX: MUL/MULH/DIV/REM signed x signed, MULHSU signed A x unsigned B, others unsigned.
REQ-018 SHALL return low N bits for MUL and high N bits of the 2N-bit product for MULH/MULHSU/MULHU.
REQ-019 SHALL give remainder the sign of the dividend; quotient truncates toward zero.
REQ-020 SHALL, for B == 0, return all-ones for DIV/DIVU and A for REM/REMU, with DONE one cycle after accepting edge (IDLE->DONE).
REQ-021 SHALL, for signed overflow (A = -2^(N-1), B = -1), return A for DIV and 0 for REM, latency 1 as REQ-020.
REQ-022 SHALL transition DONE->IDLE when START low, DONE->CALC (or DONE->DONE for REQ-020/021 cases) when START high.

Reset
REQ-023 SHALL on reset (any time, including mid-CALC) force IDLE, BUSY=0, DONE=0, RESULT=0, ZERO=1, iteration counter 0.
REQ-024 SHALL discard any in-flight operation on reset; no DONE for it after reset releases.

Configuration
REQ-025 SHALL compile divide hardware only when macro ALU_MDU_DIV_EN is defined.
REQ-026 SHALL, without ALU_MDU_DIV_EN, complete OP 4-7 as IDLE->DONE in 1 cycle with RESULT=0, ZERO=1; multiply behaviour unchanged.

Structure
REQ-027 SHALL place OP encodings and FSM state encoding in shared package alu_pkg alongside existing ALU op constants.
REQ-028 SHALL use one sub-module alu_mdu_neg (N-bit conditional two's-complement negate) for operand magnitude and FIX correction.

Verification (N=32)
REQ-029 SHALL verify MUL A=7, B=0xFFFFFFFD -> RESULT 0xFFFFFFEB, ZERO 0, DONE exactly 34 cycles after START edge.
REQ-030 SHALL verify MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-031 SHALL verify DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM same operands -> 0, ZERO 1, DONE 1 cycle after START.
REQ-032 SHALL verify DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF, DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
REQ-033 SHALL verify START pulsed mid-CALC is ignored (result of first op unchanged) and back-to-back START in DONE cycle yields second DONE 34 cycles later.
REQ-034 SHALL verify reset asserted at CALC cycle 10 -> BUSY 0, DONE 0, RESULT 0, ZERO 1 immediately, no DONE afterwards; with ALU_MDU_DIV_EN undefined, DIV 9/3 -> RESULT 0, DONE after 1 cycle.
